// File: rtl/pipe_reduce.sv
// Pipelined two-level reduction: per-group OR/AND, then AND/OR across the groups.
// Every stage shifts together when the output is free or being drained, and all stages
// freeze together otherwise. o_hits counts transferred results equal to 1 and saturates.
module pipe_reduce #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned GROUP    = 2,
  parameter int unsigned PIPE_MID = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_mode,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_data,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_hits
);

  localparam int unsigned NumGroups = WIDTH / GROUP;

  logic             advance;
  logic [WIDTH-1:0] in_data_q;
  logic             in_mode_q;
  logic             in_valid_q;
  logic [NumGroups-1:0] grp_c;
  logic [NumGroups-1:0] mid_grp;
  logic             mid_mode;
  logic             mid_valid;
  logic             out_data_d;
  logic             out_data_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] hits_d;
  logic [CNT_W-1:0] hits_q;

  // The pipeline moves only when the output slot is empty or being taken downstream.
  assign advance = i_ready | ~out_valid_q;
  assign o_ready = advance;

  // Input stage: capture the beat; data is only loaded for real beats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_data_q  <= '0;
      in_mode_q  <= 1'b0;
      in_valid_q <= 1'b0;
    end else if (advance) begin
      in_valid_q <= i_valid;
      if (i_valid) begin
        in_data_q <= i_data;
        in_mode_q <= i_mode;
      end
    end
  end

  // Inner reduction: mode 0 ORs each group, mode 1 ANDs each group.
  always_comb begin
    grp_c = '0;
    for (int g = 0; g < NumGroups; g++) begin
      grp_c[g] = in_mode_q ? (&in_data_q[g*GROUP +: GROUP]) : (|in_data_q[g*GROUP +: GROUP]);
    end
  end

  if (PIPE_MID != 0) begin : g_mid
    logic [NumGroups-1:0] grp_q;
    logic                 mode_q;
    logic                 valid_q;

    // Optional mid stage between inner and outer reduction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        grp_q   <= '0;
        mode_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (advance) begin
        grp_q   <= grp_c;
        mode_q  <= in_mode_q;
        valid_q <= in_valid_q;
      end
    end

    assign mid_grp   = grp_q;
    assign mid_mode  = mode_q;
    assign mid_valid = valid_q;
  end else begin : g_no_mid
    assign mid_grp   = grp_c;
    assign mid_mode  = in_mode_q;
    assign mid_valid = in_valid_q;
  end

  // Outer reduction: mode 0 ANDs the group results, mode 1 ORs them.
  always_comb begin
    out_data_d = mid_mode ? (|mid_grp) : (&mid_grp);
  end

  // Output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_data_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      out_data_q  <= out_data_d;
      out_valid_q <= mid_valid;
    end
  end

  assign o_data  = out_data_q;
  assign o_valid = out_valid_q;

  // Hit counter next state: clear wins over a concurrent hit; saturate instead of wrapping.
  always_comb begin
    hits_d = hits_q;
    if (i_clr) begin
      hits_d = '0;
    end else if (out_valid_q && i_ready && out_data_q && (hits_q != {CNT_W{1'b1}})) begin
      hits_d = hits_q + 1'b1;
    end
  end

  // Hit counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hits_q <= '0;
    end else begin
      hits_q <= hits_d;
    end
  end

  assign o_hits = hits_q;

endmodule

// File: tb/tb_pipe_reduce.sv
// Scoreboard bench for pipe_reduce: stimulus pushes expected results, a monitor pops them
// on every output transfer. Two extra instances cover PIPE_MID=0 and a 16-bit/4-group build.
module tb_pipe_reduce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       mode;
  logic       valid;
  logic       o_ready;
  logic       o_data;
  logic       o_valid;
  logic       rdy;
  logic       clr;
  logic [3:0] hits;

  logic [7:0]  d2_data;
  logic        d2_mode, d2_valid, d2_or, d2_od, d2_ov;
  logic [3:0]  d2_hits;
  logic [15:0] d3_data;
  logic        d3_mode, d3_valid, d3_or, d3_od, d3_ov;
  logic [3:0]  d3_hits;
  logic        one  = 1'b1;
  logic        zero = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lat_on = 1'b0;
  logic exp_q[$];
  int   acc_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pipe_reduce #(.WIDTH(8), .GROUP(2), .PIPE_MID(1), .CNT_W(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_mode(mode), .i_valid(valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(rdy), .i_clr(clr),
    .o_hits(hits)
  );

  pipe_reduce #(.WIDTH(8), .GROUP(2), .PIPE_MID(0), .CNT_W(4)) u_dut_nomid (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d2_data), .i_mode(d2_mode), .i_valid(d2_valid),
    .o_ready(d2_or), .o_data(d2_od), .o_valid(d2_ov), .i_ready(one), .i_clr(zero),
    .o_hits(d2_hits)
  );

  pipe_reduce #(.WIDTH(16), .GROUP(4), .PIPE_MID(1), .CNT_W(4)) u_dut_wide (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d3_data), .i_mode(d3_mode), .i_valid(d3_valid),
    .o_ready(d3_or), .o_data(d3_od), .o_valid(d3_ov), .i_ready(one), .i_clr(zero),
    .o_hits(d3_hits)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d need=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, record the expected result.
  task automatic send(input logic [7:0] d, input logic m, input logic e, output int acc);
    int n;
    n = 0;
    data = d; mode = m; valid = 1'b1;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=o_ready 0 need=1");
    end
    @(posedge clk); #1;
    acc = cyc;
    exp_q.push_back(e);
    acc_q.push_back(acc);
    valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been transferred.
  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("drain_remaining", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: a transfer happens at the next rising edge whenever o_valid & i_ready here.
  always @(negedge clk) begin
    if (rst_n && o_valid && rdy) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output got=%0b need=no output at t=%0t", o_data, $time);
      end else begin
        logic e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("result", int'(o_data), int'(e));
        if (lat_on) check("latency_edges", cyc - a, 2);
      end
    end
  end

  initial begin
    int   acc;
    int   rel_cyc;
    bit   idle_ok;
    logic [7:0]  v2_d[2];
    logic [15:0] v3_d[2];
    logic        v_m[2];
    logic        v_e[2];

    // Reset state with random inputs, before any clock edge.
    rst_n = 1'b0;
    data = 8'($urandom); mode = 1'($urandom); valid = 1'b1; rdy = 1'($urandom);
    clr = 1'b0;
    d2_data = '0; d2_mode = 1'b0; d2_valid = 1'b0;
    d3_data = '0; d3_mode = 1'b0; d3_valid = 1'b0;
    #2;
    check("reset_o_valid", int'(o_valid), 0);
    check("reset_o_data", int'(o_data), 0);
    check("reset_o_hits", int'(hits), 0);
    check("reset_o_ready", int'(o_ready), 1);
    valid = 1'b0; rdy = 1'b1;
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back mixed-mode beats, latency 2 edges.
    lat_on = 1'b1;
    send(8'hAA, 1'b0, 1'b1, acc);
    send(8'h0F, 1'b0, 1'b0, acc);
    send(8'h03, 1'b1, 1'b1, acc);
    send(8'h55, 1'b1, 1'b0, acc);
    wait_empty();
    lat_on = 1'b0;
    @(negedge clk);
    check("hits_after_stream", int'(hits), 2);

    // Backpressure: three beats in flight, downstream stalled for five cycles.
    @(posedge clk); #1;
    rdy = 1'b0;
    send(8'hFF, 1'b0, 1'b1, acc);
    send(8'h00, 1'b1, 1'b0, acc);
    send(8'hF0, 1'b1, 1'b1, acc);
    data = 8'hFF; mode = 1'b0; valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_o_ready", int'(o_ready), 0);
      check("stall_o_valid", int'(o_valid), 1);
      check("stall_o_data", int'(o_data), 1);
    end
    @(posedge clk); #1;
    valid = 1'b0; rdy = 1'b1;
    wait_empty();

    // Asynchronous reset between edges with beats in flight.
    rdy = 1'b0;
    send(8'hAA, 1'b0, 1'b1, acc);
    send(8'hFF, 1'b1, 1'b1, acc);
    @(posedge clk); #1;
    check("pre_reset_o_valid", int'(o_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_o_valid", int'(o_valid), 0);
    check("async_rst_o_data", int'(o_data), 0);
    check("async_rst_o_ready", int'(o_ready), 1);
    exp_q.delete();
    acc_q.delete();
    #2 rst_n = 1'b1;
    rdy = 1'b1;
    idle_ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (o_valid) idle_ok = 1'b0;
    end
    check("no_stale_after_reset", int'(idle_ok), 1);

    // Accept at the first edge after release.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    rel_cyc = cyc;
    lat_on = 1'b1;
    send(8'h03, 1'b1, 1'b1, acc);
    check("first_edge_accept", acc, rel_cyc + 1);
    wait_empty();
    lat_on = 1'b0;

    // Saturation: 17 more hits on a 4-bit counter.
    repeat (17) send(8'hAA, 1'b0, 1'b1, acc);
    wait_empty();
    @(negedge clk);
    check("hits_saturated", int'(hits), 15);

    // Clear with a concurrent hit.
    @(posedge clk); #1;
    rdy = 1'b0;
    send(8'hAA, 1'b0, 1'b1, acc);
    @(negedge clk);
    while (!o_valid) @(negedge clk);
    @(posedge clk); #1;
    rdy = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_beats_hit", int'(hits), 0);
    check("clr_drained", exp_q.size(), 0);

    // PIPE_MID=0 (latency 1) and WIDTH=16/GROUP=4 (latency 2).
    v2_d[0] = 8'hAA;     v3_d[0] = 16'h1111; v_m[0] = 1'b0; v_e[0] = 1'b1;
    v2_d[1] = 8'h0F;     v3_d[1] = 16'h1111; v_m[1] = 1'b1; v_e[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      d2_data = v2_d[i]; d2_mode = 1'b0; d2_valid = 1'b1;
      d3_data = v3_d[i]; d3_mode = v_m[i]; d3_valid = 1'b1;
      @(posedge clk); #1;
      d2_valid = 1'b0; d3_valid = 1'b0;
      @(negedge clk);
      check("nomid_not_early", int'(d2_ov), 0);
      @(negedge clk);
      check("nomid_o_valid", int'(d2_ov), 1);
      check("nomid_o_data", int'(d2_od), int'(v_e[i]));
      check("wide_not_early", int'(d3_ov), 0);
      @(negedge clk);
      check("wide_o_valid", int'(d3_ov), 1);
      check("wide_o_data", int'(d3_od), int'(v_e[i]));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reduce.md
PIPE_REDUCE -- requirements
Module: pipe_reduce

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width; a multiple of GROUP, and at least 2.
REQ-002 SHALL have parameter GROUP, default 2: bits per inner-reduction group, range 2..8.
REQ-003 SHALL have parameter PIPE_MID, default 1: 1 inserts a register between inner and outer reduction; 0 removes it.
REQ-004 SHALL have parameter CNT_W, default 16: width of o_hits.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_data, input, WIDTH bits: operand.
REQ-008 SHALL have port i_mode, input, 1 bit: 0 = AND-of-ORs, 1 = OR-of-ANDs; travels with its beat.
REQ-009 SHALL have port i_valid, input, 1 bit: upstream beat present.
REQ-010 SHALL have port o_ready, output, 1 bit: beat accepted at an edge where i_valid & o_ready.
REQ-011 SHALL have port o_data, output, 1 bit: reduction result.
REQ-012 SHALL have port o_valid, output, 1 bit: o_data holds a result.
REQ-013 SHALL have port i_ready, input, 1 bit: downstream accepts; transfer occurs at an edge where o_valid & i_ready.
REQ-014 SHALL have port i_clr, input, 1 bit: synchronous clear of o_hits.
REQ-015 SHALL have port o_hits, output, CNT_W bits: saturating count of transferred results equal to 1.

Function
REQ-016 SHALL partition i_data into WIDTH/GROUP groups, group g = bits [g*GROUP+GROUP-1 : g*GROUP].
REQ-017 SHALL, for mode 0, OR each group and AND the group results; for mode 1, AND each group and OR the group results.
REQ-018 SHALL register the stages in this order: input stage (data, mode, valid), optional mid stage (group results, mode, valid), output stage (o_data, o_valid).
REQ-019 SHALL have latency 2+PIPE_MID rising edges, counting the acceptance edge: with PIPE_MID=1, a beat accepted at edge N gives o_valid=1 after edge N+2.
REQ-020 SHALL define advance = i_ready | ~o_valid, with o_ready = advance (combinational).
REQ-021 SHALL shift all stages together when advance=1; valid bits load from the preceding stage, and i_valid loads into the input stage.
REQ-022 SHALL freeze every stage (data and valid) when advance=0; o_data and o_valid SHALL then be held stable.
REQ-023 SHALL not compress bubbles: an empty stage propagates as valid=0, and beat order SHALL be preserved.
REQ-024 SHALL ignore i_data and i_mode when i_valid=0 or o_ready=0; beats are never dropped or duplicated.
REQ-025 SHALL increment o_hits on each transfer with o_data=1, saturating at 2^CNT_W-1 with no wrap.
REQ-026 SHALL give i_clr priority over increment: a clear in the same cycle as a hit yields 0.
REQ-027 SHALL treat a change of i_mode between beats as per-beat, so that mixed-mode streams produce independently correct results.

Reset
REQ-028 SHALL, while i_rst_n=0, immediately force all valid bits, data registers, o_data, o_valid and o_hits to 0; o_ready SHALL be 1 (pipeline empty, so advance=1).
REQ-029 SHALL discard in-flight beats on reset mid-stream; no stale result SHALL appear after release.
REQ-030 SHALL accept a beat at the first rising edge after i_rst_n deasserts.

Verification (WIDTH=8, GROUP=2, PIPE_MID=1, CNT_W=4 unless stated)
REQ-031 SHALL verify: i_rst_n low, random inputs -> o_valid=0, o_data=0, o_hits=0, o_ready=1, with no clock edge required.
REQ-032 SHALL verify: i_ready=1, beats 8'hAA/m0, 8'h0F/m0, 8'h03/m1, 8'h55/m1 on consecutive edges N..N+3 -> o_data 1,0,1,0 with o_valid=1 after edges N+2..N+5.
REQ-033 SHALL verify: 3 beats in flight, i_ready=0 for 5 cycles -> o_ready=0, o_data stable, no acceptance; after release, all 3 results in order, none lost.
REQ-034 SHALL verify: 17 transfers of result 1 -> o_hits=15 (saturated); i_clr with a concurrent hit -> o_hits=0 next cycle.
REQ-035 SHALL verify: i_rst_n pulsed low between edges with 2 beats in flight -> o_valid drops without a clock edge; after release, no output until a new beat is accepted.
REQ-036 SHALL verify: PIPE_MID=0, 8'hAA/m0 accepted at edge N -> o_data=1, o_valid=1 after edge N+1; WIDTH=16, GROUP=4, 16'h1111/m0 -> 1.
